// File: rtl/sgd_mem_rd_cmd_gen_pkg.sv
// Shared constants, tags and types for the SGD memory read command generator.
package sgd_mem_rd_cmd_gen_pkg;

  localparam logic [7:0] MEM_RD_A_TAG      = 8'h0a;
  localparam logic [7:0] MEM_RD_B_TAG      = 8'h0b;
  localparam int         NUM_BITS_PER_CL   = 512;
  localparam int         CL_BYTES          = NUM_BITS_PER_CL / 8;
  localparam int         CL_SHIFT          = $clog2(CL_BYTES);
  localparam int         A_FIFO_DEPTH_BITS = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  typedef enum logic {
    STREAM_A,
    STREAM_B
  } stream_e;

  // Cachelines in the next burst: whatever is left, capped at the burst limit.
  function automatic logic [31:0] burst_chunk(input logic [31:0] remaining,
                                               input logic [31:0] max_cl);
    return (remaining < max_cl) ? remaining : max_cl;
  endfunction

endpackage

// File: rtl/axis_mem_cmd.sv
// Memory command stream: byte address plus byte length, valid/ready handshake.
interface axis_mem_cmd;

  logic        valid;
  logic        ready;
  logic [63:0] address;
  logic [31:0] length;

  modport master (
    output valid,
    output address,
    output length,
    input  ready
  );

  modport slave (
    input  valid,
    input  address,
    input  length,
    output ready
  );

endinterface

// File: rtl/sgd_rd_credit.sv
// Per-stream FIFO credit counter: chunk is taken on command handshake, one credit
// comes back per popped cacheline; a pop into a full counter is flagged sticky.
module sgd_rd_credit #(
  parameter int DEPTH_BITS = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_err,
  input  logic              take,
  input  logic [DEPTH_BITS:0] amount,
  input  logic              pop,
  output logic [DEPTH_BITS:0] credit,
  output logic              err
);

  localparam logic [DEPTH_BITS:0] FULL = {1'b1, {DEPTH_BITS{1'b0}}};

  logic [DEPTH_BITS:0] sum;
  logic [DEPTH_BITS:0] credit_next;
  logic                overflow;

  // FULL+1 still fits in DEPTH_BITS+1 bits, so saturating after the add is safe.
  always_comb begin
    sum         = credit - (take ? amount : '0) + {{DEPTH_BITS{1'b0}}, pop};
    credit_next = (sum > FULL) ? FULL : sum;
  end

  assign overflow = pop && (credit == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit <= FULL;
      err    <= 1'b0;
    end else begin
      credit <= credit_next;
      if (clr_err) begin
        err <= overflow;
      end else if (overflow) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sgd_mem_rd_cmd_gen.sv
// Streams A (dataset) and B (labels) read commands for a number of epochs,
// round-robin between streams and throttled by per-stream FIFO credits.
module sgd_mem_rd_cmd_gen
  import sgd_mem_rd_cmd_gen_pkg::*;
#(
  parameter int MAX_BURST_CL    = 64,
  parameter int FIFO_DEPTH_BITS = A_FIFO_DEPTH_BITS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] addr_a,
  input  logic [63:0] addr_b,
  input  logic [31:0] num_cl_a,
  input  logic [31:0] num_cl_b,
  input  logic [15:0] num_epochs,
  axis_mem_cmd.master m_axis_mem_cmd,
  output logic [7:0]  cmd_tag,
  input  logic        a_cl_pop,
  input  logic        b_cl_pop,
  output logic        busy,
  output logic        done,
  output logic        credit_err
);

  localparam int          CW     = FIFO_DEPTH_BITS + 1;
  localparam logic [31:0] MAX_CL = 32'(MAX_BURST_CL);

  state_e        state;
  state_e        state_next;

  logic [63:0]   base_a;
  logic [63:0]   base_b;
  logic [63:0]   cur_a;
  logic [63:0]   cur_b;
  logic [31:0]   len_a;
  logic [31:0]   len_b;
  logic [31:0]   rem_a;
  logic [31:0]   rem_b;
  logic [15:0]   epochs;
  logic [15:0]   epoch;
  logic          prio_b;
  stream_e       cmd_stream;
  logic [CW-1:0] cmd_chunk;

  logic [CW-1:0] credit_a;
  logic [CW-1:0] credit_b;
  logic          err_a;
  logic          err_b;

  logic [31:0]   chunk_a;
  logic [31:0]   chunk_b;
  logic          elig_a;
  logic          elig_b;
  logic          start_acc;
  logic          empty_job;
  logic          hs;
  logic          hs_a;
  logic          hs_b;
  logic [31:0]   rem_a_after;
  logic [31:0]   rem_b_after;
  logic [63:0]   step;
  logic          last_epoch;
  logic          job_end;
  logic          wrap;
  logic          load;
  logic          sel_b;

  // Eligibility looks at registered credit only; a pop this cycle helps next cycle.
  assign chunk_a = burst_chunk(rem_a, MAX_CL);
  assign chunk_b = burst_chunk(rem_b, MAX_CL);
  assign elig_a  = (rem_a != 32'd0) && (32'(credit_a) >= chunk_a);
  assign elig_b  = (rem_b != 32'd0) && (32'(credit_b) >= chunk_b);

  assign start_acc = (state == ST_IDLE) && start;
  assign empty_job = (num_epochs == 16'd0) ||
                     ((num_cl_a == 32'd0) && (num_cl_b == 32'd0));

  assign hs   = m_axis_mem_cmd.valid && m_axis_mem_cmd.ready;
  assign hs_a = hs && (cmd_stream == STREAM_A);
  assign hs_b = hs && (cmd_stream == STREAM_B);
  assign step = 64'(cmd_chunk) << CL_SHIFT;

  assign rem_a_after = hs_a ? (rem_a - 32'(cmd_chunk)) : rem_a;
  assign rem_b_after = hs_b ? (rem_b - 32'(cmd_chunk)) : rem_b;

  assign last_epoch = (17'(epoch) + 17'd1) >= 17'(epochs);
  assign job_end    = hs && (rem_a_after == 32'd0) && (rem_b_after == 32'd0) && last_epoch;
  assign wrap       = (state == ST_RUN) && !m_axis_mem_cmd.valid &&
                      (rem_a == 32'd0) && (rem_b == 32'd0) && !last_epoch;
  assign load       = (state == ST_RUN) && !m_axis_mem_cmd.valid && (elig_a || elig_b);

  // Preferred stream wins if eligible, otherwise the other one (load implies one is).
  assign sel_b = prio_b ? elig_b : !elig_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = empty_job ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (job_end) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Job registers and the command output stage; payload only reloads while valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_a                 <= '0;
      base_b                 <= '0;
      cur_a                  <= '0;
      cur_b                  <= '0;
      len_a                  <= '0;
      len_b                  <= '0;
      rem_a                  <= '0;
      rem_b                  <= '0;
      epochs                 <= '0;
      epoch                  <= '0;
      prio_b                 <= 1'b0;
      cmd_stream             <= STREAM_A;
      cmd_chunk              <= '0;
      m_axis_mem_cmd.valid   <= 1'b0;
      m_axis_mem_cmd.address <= '0;
      m_axis_mem_cmd.length  <= '0;
      cmd_tag                <= '0;
    end else if (start_acc) begin
      base_a <= addr_a;
      base_b <= addr_b;
      cur_a  <= addr_a;
      cur_b  <= addr_b;
      len_a  <= num_cl_a;
      len_b  <= num_cl_b;
      rem_a  <= num_cl_a;
      rem_b  <= num_cl_b;
      epochs <= num_epochs;
      epoch  <= '0;
      prio_b <= 1'b0;
    end else if (state == ST_RUN) begin
      if (hs) begin
        m_axis_mem_cmd.valid <= 1'b0;
        prio_b               <= ~prio_b;
        rem_a                <= rem_a_after;
        rem_b                <= rem_b_after;
        if (hs_a) begin
          cur_a <= cur_a + step;
        end
        if (hs_b) begin
          cur_b <= cur_b + step;
        end
      end else if (wrap) begin
        cur_a <= base_a;
        cur_b <= base_b;
        rem_a <= len_a;
        rem_b <= len_b;
        epoch <= epoch + 16'd1;
      end else if (load) begin
        m_axis_mem_cmd.valid   <= 1'b1;
        m_axis_mem_cmd.address <= sel_b ? cur_b : cur_a;
        m_axis_mem_cmd.length  <= (sel_b ? chunk_b : chunk_a) << CL_SHIFT;
        cmd_tag                <= sel_b ? MEM_RD_B_TAG : MEM_RD_A_TAG;
        cmd_stream             <= sel_b ? STREAM_B : STREAM_A;
        cmd_chunk              <= sel_b ? CW'(chunk_b) : CW'(chunk_a);
      end
    end
  end

  sgd_rd_credit #(
    .DEPTH_BITS(FIFO_DEPTH_BITS)
  ) u_credit_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_err(start_acc),
    .take   (hs_a),
    .amount (cmd_chunk),
    .pop    (a_cl_pop),
    .credit (credit_a),
    .err    (err_a)
  );

  sgd_rd_credit #(
    .DEPTH_BITS(FIFO_DEPTH_BITS)
  ) u_credit_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_err(start_acc),
    .take   (hs_b),
    .amount (cmd_chunk),
    .pop    (b_cl_pop),
    .credit (credit_b),
    .err    (err_b)
  );

  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);
  assign credit_err = err_a | err_b;

endmodule

// File: tb/tb_sgd_mem_rd_cmd_gen.sv
// Scoreboard bench: directed jobs push hand-computed commands into a queue, a
// negedge monitor pops and compares on every handshake.
module tb_sgd_mem_rd_cmd_gen;

  localparam logic [7:0] TAG_A = 8'h0a;
  localparam logic [7:0] TAG_B = 8'h0b;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] len;
    logic [7:0]  tag;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] addr_a = '0;
  logic [63:0] addr_b = '0;
  logic [31:0] num_cl_a = '0;
  logic [31:0] num_cl_b = '0;
  logic [15:0] num_epochs = '0;
  logic        a_cl_pop = 1'b0;
  logic        b_cl_pop = 1'b0;
  logic [7:0]  cmd_tag;
  logic        busy;
  logic        done;
  logic        credit_err;

  axis_mem_cmd cmd_if ();

  int   total = 0;
  int   bad = 0;
  int   hs_count = 0;
  int   owed_a = 0;
  int   owed_b = 0;
  int   man_a = 0;
  bit   auto_pop = 1'b1;
  cmd_t sb_q[$];

  sgd_mem_rd_cmd_gen dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .addr_a        (addr_a),
    .addr_b        (addr_b),
    .num_cl_a      (num_cl_a),
    .num_cl_b      (num_cl_b),
    .num_epochs    (num_epochs),
    .m_axis_mem_cmd(cmd_if),
    .cmd_tag       (cmd_tag),
    .a_cl_pop      (a_cl_pop),
    .b_cl_pop      (b_cl_pop),
    .busy          (busy),
    .done          (done),
    .credit_err    (credit_err)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic [63:0] addr, input logic [31:0] len, input logic [7:0] tag);
    cmd_t c;
    c.addr = addr;
    c.len  = len;
    c.tag  = tag;
    sb_q.push_back(c);
  endtask

  // Monitor: every handshake must match the oldest expected command.
  initial forever begin
    cmd_t e;
    @(negedge clk);
    if (rst_n && cmd_if.valid && cmd_if.ready) begin
      hs_count++;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_cmd: got addr 0x%0h len %0d tag 0x%0h want none",
                 cmd_if.address, cmd_if.length, cmd_tag);
      end else begin
        e = sb_q.pop_front();
        check("cmd_addr", cmd_if.address, e.addr);
        check("cmd_len", 64'(cmd_if.length), 64'(e.len));
        check("cmd_tag", 64'(cmd_tag), 64'(e.tag));
      end
    end
  end

  // Downstream FIFO model: in auto mode drains one cacheline per cycle of what was issued.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      owed_a = 0;
      owed_b = 0;
    end else if (cmd_if.valid && cmd_if.ready && auto_pop) begin
      if (cmd_tag == TAG_A) owed_a += int'(cmd_if.length >> 6);
      else                  owed_b += int'(cmd_if.length >> 6);
    end
    a_cl_pop = 1'b0;
    b_cl_pop = 1'b0;
    if (rst_n && man_a > 0) begin
      a_cl_pop = 1'b1;
      man_a--;
    end else if (rst_n && owed_a > 0) begin
      a_cl_pop = 1'b1;
      owed_a--;
    end
    if (rst_n && owed_b > 0) begin
      b_cl_pop = 1'b1;
      owed_b--;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    man_a = 0;
    sb_q.delete();
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; returns one cycle after the start cycle.
  task automatic start_job(input logic [63:0] a, input logic [63:0] b,
                           input logic [31:0] na, input logic [31:0] nb, input logic [15:0] ne);
    addr_a     = a;
    addr_b     = b;
    num_cl_a   = na;
    num_cl_b   = nb;
    num_epochs = ne;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < budget);
    check({name, "_done"}, 64'(done), 64'd1);
    @(negedge clk);
    check({name, "_pulse"}, 64'(done), 64'd0);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_pending"}, 64'(sb_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cmd_if.valid !== 1'b1 && n < budget);
    check({name, "_valid_seen"}, 64'(cmd_if.valid), 64'd1);
  endtask

  initial begin
    int h0;
    cmd_if.ready = 1'b1;

    #2;
    check("rst_valid", 64'(cmd_if.valid), 64'd0);
    check("rst_addr", cmd_if.address, 64'd0);
    check("rst_len", 64'(cmd_if.length), 64'd0);
    check("rst_tag", 64'(cmd_tag), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_cerr", 64'(credit_err), 64'd0);
    do_reset();

    // 200 CL on A only: 64+64+64+8 cachelines.
    push_cmd(64'h1000, 32'd4096, TAG_A);
    push_cmd(64'h2000, 32'd4096, TAG_A);
    push_cmd(64'h3000, 32'd4096, TAG_A);
    push_cmd(64'h4000, 32'd512,  TAG_A);
    start_job(64'h1000, 64'h9000, 32'd200, 32'd0, 16'd1);
    check("single_busy_c1", 64'(busy), 64'd1);
    check("single_valid_c1", 64'(cmd_if.valid), 64'd0);
    @(posedge clk);
    #1;
    check("single_valid_c2", 64'(cmd_if.valid), 64'd1);
    check("single_addr_c2", cmd_if.address, 64'h1000);
    wait_done("single", 200);

    push_cmd(64'h20000, 32'd4096, TAG_A);
    push_cmd(64'h80000, 32'd4096, TAG_B);
    push_cmd(64'h21000, 32'd4096, TAG_A);
    push_cmd(64'h81000, 32'd4096, TAG_B);
    start_job(64'h20000, 64'h80000, 32'd128, 32'd128, 16'd1);
    wait_done("interleave", 200);

    push_cmd(64'h40000, 32'd4096, TAG_A);
    push_cmd(64'h40000, 32'd4096, TAG_A);
    push_cmd(64'h40000, 32'd4096, TAG_A);
    start_job(64'h40000, 64'h0, 32'd64, 32'd0, 16'd3);
    wait_done("epochs", 200);

    h0 = hs_count;
    start_job(64'h40000, 64'h50000, 32'd64, 32'd64, 16'd0);
    check("ep0_done_c1", 64'(done), 64'd1);
    check("ep0_busy_c1", 64'(busy), 64'd1);
    cycles(1);
    check("ep0_done_c2", 64'(done), 64'd0);
    check("ep0_busy_c2", 64'(busy), 64'd0);
    start_job(64'h40000, 64'h50000, 32'd0, 32'd0, 16'd2);
    check("nocl_done_c1", 64'(done), 64'd1);
    cycles(4);
    check("empty_no_cmds", 64'(hs_count), 64'(h0));

    do_reset();
    cmd_if.ready = 1'b0;
    push_cmd(64'h50000, 32'd4096, TAG_A);
    start_job(64'h50000, 64'h0, 32'd64, 32'd0, 16'd1);
    wait_valid("bp", 20);
    for (int i = 0; i < 10; i++) begin
      check("bp_addr", cmd_if.address, 64'h50000);
      check("bp_len", 64'(cmd_if.length), 64'd4096);
      check("bp_tag", 64'(cmd_tag), 64'(TAG_A));
      @(negedge clk);
    end
    h0 = hs_count;
    @(posedge clk);
    #1;
    cmd_if.ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_first_ready_hs", 64'(hs_count), 64'(h0 + 1));
    wait_done("bp", 50);

    do_reset();
    auto_pop = 1'b0;
    h0 = hs_count;
    for (int i = 0; i < 32; i++) push_cmd(64'h100000 + 64'(i) * 64'd4096, 32'd4096, TAG_A);
    start_job(64'h100000, 64'h0, 32'd4096, 32'd0, 16'd1);
    cycles(100);
    check("stall_count", 64'(hs_count), 64'(h0 + 32));
    check("stall_valid", 64'(cmd_if.valid), 64'd0);
    man_a = 1;
    cycles(10);
    check("stall_one_pop_valid", 64'(cmd_if.valid), 64'd0);
    check("stall_one_pop_count", 64'(hs_count), 64'(h0 + 32));
    push_cmd(64'h100000 + 64'd32 * 64'd4096, 32'd4096, TAG_A);
    man_a = 63;
    cycles(80);
    check("stall_resume_count", 64'(hs_count), 64'(h0 + 33));
    check("stall_pending", 64'(sb_q.size()), 64'd0);
    check("stall_busy", 64'(busy), 64'd1);
    do_reset();
    auto_pop = 1'b1;

    cmd_if.ready = 1'b0;
    push_cmd(64'h60000, 32'd4096, TAG_A);
    start_job(64'h60000, 64'h0, 32'd64, 32'd0, 16'd1);
    wait_valid("abort", 20);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_valid", 64'(cmd_if.valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    cmd_if.ready = 1'b1;
    @(posedge clk);
    #1;
    push_cmd(64'h70000, 32'd4096, TAG_A);
    start_job(64'h70000, 64'h0, 32'd64, 32'd0, 16'd1);
    wait_done("after_abort", 100);

    do_reset();
    check("cerr_before", 64'(credit_err), 64'd0);
    man_a = 1;
    cycles(3);
    check("cerr_set", 64'(credit_err), 64'd1);
    cycles(3);
    check("cerr_sticky", 64'(credit_err), 64'd1);
    start_job(64'h0, 64'h0, 32'd0, 32'd0, 16'd0);
    check("cerr_cleared", 64'(credit_err), 64'd0);
    cycles(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sgd_mem_rd_cmd_gen.md
# sgd_mem_rd_cmd_gen

Issues memory read commands that stream the training dataset (A) and label/bias vector (B) from DRAM into the SGD engines for a configured number of epochs. It sits directly upstream of the memory read path: it drives an `axis_mem_cmd` master port plus a tag identifying the A or B stream. It throttles itself with per-stream credits so the A and B data FIFOs can never overflow.

## Interface
- `MAX_BURST_CL`, default 64: max cachelines per command; must be ≤ 2^`FIFO_DEPTH_BITS`.
- `FIFO_DEPTH_BITS`, default `` `A_FIFO_DEPTH_BITS `` (11): log2 of downstream FIFO depth in cachelines, per stream.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle job start; sampled only in IDLE.
- `addr_a`, `addr_b` in 64 each: byte base addresses, 64 B aligned; captured on `start`.
- `num_cl_a`, `num_cl_b` in 32 each: cachelines per epoch per stream; captured on `start`.
- `num_epochs` in 16: passes over A and B; captured on `start`.
- `m_axis_mem_cmd` master (`valid`, `ready`, `address[63:0]`, `length[31:0]`): read command; `length` is in bytes.
- `cmd_tag` out 8: `` `MEM_RD_A_TAG `` or `` `MEM_RD_B_TAG ``; valid with `m_axis_mem_cmd.valid`.
- `a_cl_pop`, `b_cl_pop` in 1 each: one cachelines left the A or B FIFO this cycle.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse when the job completes.
- `credit_err` out 1: sticky; a pop arrived while credit was already full. Cleared only by reset or `start`.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on `start`. Inputs are latched; epoch counter=0.
  - IDLE→DONE on `start` instead if `num_epochs`=0 or both `num_cl` are 0.
  - RUN→DONE after the handshake of the final command of the final epoch.
  - DONE→IDLE unconditionally after one cycle; `done`=1 only in DONE.
  - `start` outside IDLE is ignored.
- Per stream: current address, remaining cachelines, credit counter (`FIFO_DEPTH_BITS`+1 bits, reset to 2^`FIFO_DEPTH_BITS`).
- Chunk = min(remaining, `MAX_BURST_CL`). A stream is eligible when remaining>0 and credit ≥ chunk.
- Command payload: `address`=current address, `length`=chunk×64, `cmd_tag` per stream.
- On handshake for a stream: address += chunk×64; remaining −= chunk; credit −= chunk.
- Credit update in the same cycle: credit_next = credit − (handshake ? chunk : 0) + pop.
- A pop with credit at max saturates the counter and sets `credit_err`.
- Arbitration: round-robin priority bit, initialised to A on `start`, toggled after every handshake.
  - If the preferred stream is ineligible, the other eligible stream is chosen.
  - If neither is eligible, no command is loaded.
- Epoch wrap: when both remaining counts are 0 and epoch < `num_epochs`−1, reload base addresses and counts, epoch++.
  - The wrap takes the cycle after the last handshake.
  - Credits are not reset at epoch wrap.

## Timing
- Reset values:
  - `m_axis_mem_cmd.valid`=0, `address`=0, `length`=0, `cmd_tag`=0.
  - `busy`=0, `done`=0, `credit_err`=0.
  - State IDLE; credits full.
- Output registers load only while `valid`=0. Payload and tag stay stable while `valid`=1 and `ready`=0.
- `start` at cycle 0: RUN at cycle 1, first `valid` at cycle 2.
- After a handshake, `valid`=0 for one cycle, then the next command (if eligible) appears. Peak rate is one command per 2 cycles.
- DONE occurs the cycle after the last handshake; `done` is high for exactly 1 cycle.
- Eligibility is evaluated on registered credit at load time; a pop in the load cycle counts from the next cycle.
- Reset asserted mid-job aborts immediately. Any pending command is dropped (`valid`=0) and credits return to full.

## Structure
- Shared defines header holds: `MEM_RD_A_TAG`, `MEM_RD_B_TAG`, `NUM_BITS_PER_CL`, `A_FIFO_DEPTH_BITS`, and CL bytes (`NUM_BITS_PER_CL`/8).
- Uses the existing `axis_mem_cmd` interface, master modport.
- Sub-module `sgd_rd_credit` holds the credit counter (subtract-chunk/add-pop, saturation, error flag). It is instantiated twice, once per stream.

## Test plan
- Single stream: `num_cl_a`=200, `num_cl_b`=0, `num_epochs`=1, `ready`=1, pops keep pace → commands of 64, 64, 64, 8 CL (lengths 4096, 4096, 4096, 512 B) at addresses base+0/4096/8192/12288, all tag 0x0a, then one `done` pulse.
- Interleave: A=128 CL, B=128 CL, 1 epoch → tag order 0x0a, 0x0b, 0x0a, 0x0b.
- Credit stall: A=4096 CL, no pops → exactly 32 commands (2048 CL) issued, then `valid` stays 0. One pop alone still stalls; 64 pops → next command issues.
- Backpressure: `ready`=0 for 10 cycles with `valid`=1 → address, length and tag unchanged; handshake occurs on the first `ready`.
- Epochs and edges: `num_epochs`=3 with A=64 → three commands to the same `addr_a`. `num_epochs`=0 → `done` 1 cycle after `start`, no commands. Pop at full credit → `credit_err`=1.
- Mid-job reset: `rst_n` low while `valid`=1 → `valid`=0 and `busy`=0 immediately. After release, `start` runs a job from scratch.
